regfile_write_buffer: RTL and testbench
=======================================

Name: regfile_write_buffer

Overview:
- Write-side companion of the 32x32 register file. Accepts write-back results from the MEM/WB stage and queues them in a small FIFO.
- Drains the queue onto the register file's single write port (Write_Reg/WR/WB), only in cycles when decode is not reading, because the register file performs no read in a cycle where Write_Reg is high.
- Provides newest-wins bypass of pending, not-yet-committed writes to decode, and bounds read-induced starvation.

Parameters:
- DEPTH, 4, number of FIFO entries (power of 2, >=2)
- STARVE_MAX, 8, consecutive full-and-blocked cycles before a write is forced
- DROP_R0, 1, when 1, write-back requests to register 0 are accepted but discarded

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- wb_valid  input  1  write-back request valid
- wb_addr  input  5  destination register
- wb_data  input  32  write data
- wb_ready  output  1  buffer can accept a request
- rd_busy  input  1  decode reads the register file this cycle
- rd_stall  output  1  decode must hold its read (forced write in progress)
- Write_Reg  output  1  register file write enable (registered)
- WR  output  5  register file write address (registered)
- WB  output  32  register file write data (registered)
- byp_addr1, byp_addr2  input  5  decode source register numbers
- byp_hit1, byp_hit2  output  1  a pending write targets that register
- byp_data1, byp_data2  output  32  newest pending data for that register, 0 if no hit
- count  output  clog2(DEPTH)+1  occupancy
- empty, full  output  1  occupancy flags

Behaviour:
- Reset (async, any time):
  - Pointers, count, and starvation counter clear to 0.
  - Write_Reg=0, WR=0, WB=0, rd_stall=0.
  - All pending entries are discarded; empty=1, full=0, wb_ready=1.
- Ready/full/empty:
  - wb_ready = !full, where full = (count==DEPTH).
  - There is no enqueue-while-full even if a pop occurs in the same cycle.
- Enqueue:
  - Occurs on a clock edge with wb_valid && wb_ready.
  - If DROP_R0=1 and wb_addr==0, the request is handshaken but not stored.
- Drain decision, each edge:
  - pop = !empty && (!rd_busy || force).
  - On pop: Write_Reg<=1, WR<=head addr, WB<=head data, head advances.
  - Otherwise Write_Reg<=0; WR and WB hold their values.
  - The register file commits the write on the following edge.
- Latency:
  - A request accepted at edge N into an empty buffer with rd_busy low gives Write_Reg=1 after edge N+1.
  - The register file commits that write at edge N+2.
- Simultaneous enqueue and pop: count is unchanged; FIFO order is preserved.
- Pointer wrap: head and tail wrap modulo DEPTH; count alone distinguishes full from empty.
- Starvation:
  - starve_cnt increments on each edge where full && rd_busy; it resets to 0 otherwise.
  - force = (starve_cnt==STARVE_MAX-1) && full && rd_busy.
  - force is combinational: rd_stall=force.
  - On the forced pop, starve_cnt returns to 0.
  - Decode must repeat its read in the next cycle.
- Bypass (combinational on byp_addr1/2):
  - Search order, youngest first: FIFO entries from tail-1 back to head, then the output register (only while Write_Reg=1).
  - The first address match gives hit=1 and that entry's data.
  - Address 0 never hits when DROP_R0=1.
  - An entry enqueued on the current edge is visible the cycle after.
- Write ordering: multiple writes to the same register commit in acceptance order; the last accepted value wins.

Test Plan:
- Single write, rd_busy=0: enqueue (addr 5, 0xDEADBEEF) at edge 1 -> Write_Reg=1, WR=5, WB=0xDEADBEEF after edge 2 for one cycle; empty=1 after edge 2.
- Fill and hold:
  - rd_busy=1 with 4 enqueues (addr 1..4, data 0x11..0x44) -> full=1, wb_ready=0, a 5th request is not accepted.
  - Drop rd_busy -> WR sequence 1,2,3,4 on consecutive cycles, then empty=1.
- Bypass newest-wins: enqueue r7=0xA then r7=0xB with rd_busy=1 -> byp_addr1=7 gives hit=1, data=0xB; byp_addr2=8 gives hit=0, data=0.
- Starvation: keep full with rd_busy=1 continuously -> rd_stall=1 and a forced pop (Write_Reg=1) on the 8th full-and-blocked cycle; counter restarts afterward.
- R0 drop with DROP_R0=1: enqueue addr 0, 0x1234 -> wb_ready handshake occurs, count stays 0, Write_Reg never asserts.
- Reset mid-operation: assert rst asynchronously with 3 entries pending and Write_Reg=1 -> outputs go to 0 immediately without a clock edge, count=0, and no further writes occur after rst deasserts.

Source files
------------

// File: rtl/regfile_write_buffer.sv
// Write-back queue feeding the 32x32 register file's single write port.
// Latency: a write accepted into an empty buffer with rd_busy low drives
//   Write_Reg/WR/WB one edge later; the register file commits one edge after that.
// Backpressure: wb_ready = !full; drains only when decode is idle, except a
//   forced pop (rd_stall) after STARVE_MAX consecutive full-and-blocked cycles.
// Ports: clk/rst; wb_valid/wb_addr/wb_data/wb_ready write-back request;
//   rd_busy/rd_stall decode interlock; Write_Reg/WR/WB register file write port;
//   byp_addr*/byp_hit*/byp_data* pending-write bypass; count/empty/full occupancy.
module regfile_write_buffer #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8,
  parameter int DROP_R0    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_valid,
  input  logic [4:0]                 wb_addr,
  input  logic [31:0]                wb_data,
  output logic                       wb_ready,
  input  logic                       rd_busy,
  output logic                       rd_stall,
  output logic                       Write_Reg,
  output logic [4:0]                 WR,
  output logic [31:0]                WB,
  input  logic [4:0]                 byp_addr1,
  input  logic [4:0]                 byp_addr2,
  output logic                       byp_hit1,
  output logic                       byp_hit2,
  output logic [31:0]                byp_data1,
  output logic [31:0]                byp_data2,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX) + 1;

  logic [4:0]    addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [SW-1:0] starve_cnt;

  logic enq;
  logic store;
  logic pop;
  logic force_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign wb_ready = !full;

  // R0 writes complete the handshake but never occupy a slot.
  assign enq   = wb_valid && wb_ready;
  assign store = enq && !((DROP_R0 != 0) && (wb_addr == 5'd0));

  assign force_pop = (starve_cnt == SW'(STARVE_MAX - 1)) && full && rd_busy;
  assign rd_stall  = force_pop;
  assign pop       = !empty && (!rd_busy || force_pop);

  // Storage needs no reset: count alone defines which slots are live.
  always_ff @(posedge clk) begin
    if (store) begin
      addr_q[tail] <= wb_addr;
      data_q[tail] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      starve_cnt <= '0;
      Write_Reg  <= 1'b0;
      WR         <= '0;
      WB         <= '0;
    end else begin
      if (store) tail <= tail + 1'b1;
      if (pop)   head <= head + 1'b1;
      count <= count + CW'(store) - CW'(pop);

      Write_Reg <= pop;
      if (pop) begin
        WR <= addr_q[head];
        WB <= data_q[head];
      end

      if (force_pop)           starve_cnt <= '0;
      else if (full && rd_busy) starve_cnt <= starve_cnt + 1'b1;
      else                     starve_cnt <= '0;
    end
  end

  // Scan oldest to youngest so the last match (the youngest write) wins.
  // The output register holds the oldest not-yet-committed write.
  function automatic logic [32:0] lookup(input logic [4:0] ra);
    logic          hit;
    logic [31:0]   dat;
    logic [AW-1:0] idx;
    hit = 1'b0;
    dat = '0;
    if (Write_Reg && (WR == ra)) begin
      hit = 1'b1;
      dat = WB;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if ((CW'(i) < count) && (addr_q[idx] == ra)) begin
        hit = 1'b1;
        dat = data_q[idx];
      end
    end
    if ((DROP_R0 != 0) && (ra == 5'd0)) begin
      hit = 1'b0;
      dat = '0;
    end
    return {hit, dat};
  endfunction

  always_comb begin
    {byp_hit1, byp_data1} = lookup(byp_addr1);
    {byp_hit2, byp_data2} = lookup(byp_addr2);
  end

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Randomized bench for regfile_write_buffer against a queue-based reference model.
// Latency: inputs driven at negedge, outputs compared 1ns later, model steps at posedge.
// Backpressure: model decides acceptance/drain from occupancy and rd_busy each cycle.
module tb_regfile_write_buffer;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic        rd_busy;
  logic        rd_stall;
  logic        Write_Reg;
  logic [4:0]  WR;
  logic [31:0] WB;
  logic [4:0]  byp_addr1;
  logic [4:0]  byp_addr2;
  logic        byp_hit1;
  logic        byp_hit2;
  logic [31:0] byp_data1;
  logic [31:0] byp_data2;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  regfile_write_buffer #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX), .DROP_R0(1)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
    .rd_busy(rd_busy), .rd_stall(rd_stall),
    .Write_Reg(Write_Reg), .WR(WR), .WB(WB),
    .byp_addr1(byp_addr1), .byp_addr2(byp_addr2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
    .byp_data1(byp_data1), .byp_data2(byp_data2),
    .count(count), .empty(empty), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  ent_t        q[$];
  logic        m_wreg;
  logic [4:0]  m_wr;
  logic [31:0] m_wb;
  int          m_blocked;   // consecutive full-and-blocked cycles seen so far
  int          checks;
  int          errors;
  int          forced_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_wreg    = 1'b0;
    m_wr      = '0;
    m_wb      = '0;
    m_blocked = 0;
  endtask

  // Newest pending write to a register, youngest first: queue back to front, then output reg.
  function automatic logic [32:0] model_byp(input logic [4:0] ra);
    if (ra == 5'd0) return 33'd0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].a == ra) return {1'b1, q[i].d};
    if (m_wreg && m_wr == ra) return {1'b1, m_wb};
    return 33'd0;
  endfunction

  function automatic logic model_force(input logic busy);
    return (q.size() == DEPTH) && busy && (m_blocked == STARVE_MAX - 1);
  endfunction

  task automatic check_all();
    logic [32:0] b1;
    logic [32:0] b2;
    b1 = model_byp(byp_addr1);
    b2 = model_byp(byp_addr2);
    check("count",     32'(count),     32'(q.size()));
    check("empty",     32'(empty),     32'(q.size() == 0));
    check("full",      32'(full),      32'(q.size() == DEPTH));
    check("wb_ready",  32'(wb_ready),  32'(q.size() != DEPTH));
    check("rd_stall",  32'(rd_stall),  32'(model_force(rd_busy)));
    check("Write_Reg", 32'(Write_Reg), 32'(m_wreg));
    check("WR",        32'(WR),        32'(m_wr));
    check("WB",        WB,             m_wb);
    check("byp_hit1",  32'(byp_hit1),  32'(b1[32]));
    check("byp_data1", byp_data1,      b1[31:0]);
    check("byp_hit2",  32'(byp_hit2),  32'(b2[32]));
    check("byp_data2", byp_data2,      b2[31:0]);
  endtask

  task automatic model_edge();
    logic full_m;
    logic frc;
    ent_t e;
    full_m = (q.size() == DEPTH);
    frc    = model_force(rd_busy);
    if (frc) forced_seen++;
    if (q.size() > 0 && (!rd_busy || frc)) begin
      e      = q.pop_front();
      m_wreg = 1'b1;
      m_wr   = e.a;
      m_wb   = e.d;
    end else begin
      m_wreg = 1'b0;
    end
    if (frc)                    m_blocked = 0;
    else if (full_m && rd_busy) m_blocked++;
    else                        m_blocked = 0;
    if (wb_valid && !full_m && wb_addr != 5'd0) q.push_back({wb_addr, wb_data});
  endtask

  task automatic step(input logic v, input logic [4:0] a, input logic [31:0] d,
                      input logic busy, input logic [4:0] b1, input logic [4:0] b2);
    @(negedge clk);
    wb_valid  = v;
    wb_addr   = a;
    wb_data   = d;
    rd_busy   = busy;
    byp_addr1 = b1;
    byp_addr2 = b2;
    #1;
    check_all();
    @(posedge clk);
    model_edge();
  endtask

  task automatic rand_step(input int busy_pct);
    step($urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
         $urandom_range(0, 99) < busy_pct,
         5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    forced_seen = 0;
    rst       = 1'b1;
    wb_valid  = 1'b0;
    wb_addr   = '0;
    wb_data   = '0;
    rd_busy   = 1'b0;
    byp_addr1 = '0;
    byp_addr2 = '0;
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Single write, decode idle
    step(1, 5'd5, 32'hDEADBEEF, 0, 5'd5, 5'd6);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 5'd5, 5'd0);

    // Fill while decode busy, attempt a 5th, then drain in order
    for (int i = 1; i <= 4; i++) step(1, 5'(i), 32'(i * 'h11), 1, 5'(i), 5'd3);
    step(1, 5'd9, 32'h99, 1, 5'd9, 5'd4);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 5'd2, 5'd4);

    // Newest-wins bypass
    step(1, 5'd7, 32'hA, 1, 5'd7, 5'd8);
    step(1, 5'd7, 32'hB, 1, 5'd7, 5'd8);
    step(0, 0, 0, 1, 5'd7, 5'd8);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 5'd7, 5'd8);

    // Starvation: full and blocked continuously
    for (int i = 0; i < 24; i++) step(1, 5'(1 + i % 6), 32'h100 + 32'(i), 1, 5'd3, 5'd5);
    check("forced_pops", 32'(forced_seen > 0), 32'd1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 5'd1, 5'd2);

    // R0 drop
    step(1, 5'd0, 32'h1234, 0, 5'd0, 5'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 5'd0, 5'd0);

    // Reset mid-operation: 3 pending with Write_Reg high
    for (int i = 0; i < 4; i++) step(1, 5'(10 + i), 32'hC0 + 32'(i), 1, 5'd11, 5'd12);
    step(0, 0, 0, 0, 5'd11, 5'd13);
    @(negedge clk);
    check("pre_rst_wreg", 32'(Write_Reg), 32'd1);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 5'd11, 5'd12);

    // Randomized phases with varying decode pressure
    for (int i = 0; i < 800;  i++) rand_step(30);
    for (int i = 0; i < 800;  i++) rand_step(90);
    for (int i = 0; i < 600;  i++) rand_step(100);
    for (int i = 0; i < 400;  i++) rand_step(50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
